// File: rtl/wb_pkg.sv
// Shared widths, FSM state encoding and write payload for the writeback port arbiter.
package wb_pkg;
  localparam int unsigned REG_W            = 3;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned NUM_REGS         = 8;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wb_wr_t;
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry holding register for an MDU result that lost the write port to the pipeline.
module wb_hold_buf
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [REG_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [REG_W-1:0]  addr,
  output logic [DATA_W-1:0] data
);
  logic              valid_q, valid_d;
  logic [REG_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = load_addr;
      data_d  = load_data;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the writeback stage and the MDU,
// buffering one MDU result and forcing a stall if the pipeline starves it.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pipe_we,
  input  logic [REG_W-1:0]    pipe_reg,
  input  logic [DATA_W-1:0]   pipe_data,
  input  logic                mdu_valid,
  input  logic [REG_W-1:0]    mdu_reg,
  input  logic [DATA_W-1:0]   mdu_data,
  output logic                mdu_ready,
  input  logic                mdu_issue,
  input  logic [REG_W-1:0]    mdu_issue_reg,
  output logic                rf_we,
  output logic [REG_W-1:0]    rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                stall_req
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  wb_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rf_we_q, rf_we_d;
  wb_wr_t              rf_wr_q, rf_wr_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                stall_q, stall_d;

  logic                hb_valid, hb_load, hb_clear;
  logic [REG_W-1:0]    hb_addr;
  logic [DATA_W-1:0]   hb_data;
  logic                accept, mdu_wr;
  logic [REG_W-1:0]    mdu_wr_reg;

  // Ready depends only on the buffer state, never on the offer itself.
  assign mdu_ready = (state_q == ST_IDLE);
  assign accept    = mdu_valid && mdu_ready;

  wb_hold_buf u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hb_load),
    .clear     (hb_clear),
    .load_addr (mdu_reg),
    .load_data (mdu_data),
    .valid     (hb_valid),
    .addr      (hb_addr),
    .data      (hb_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rf_we_d    = 1'b0;
    rf_wr_d    = '0;
    hb_load    = 1'b0;
    hb_clear   = 1'b0;
    mdu_wr     = 1'b0;
    mdu_wr_reg = '0;
    busy_d     = busy_q;

    // Port winner: pipeline, then held entry, then direct MDU offer.
    if (pipe_we) begin
      rf_we_d      = 1'b1;
      rf_wr_d.addr = pipe_reg;
      rf_wr_d.data = pipe_data;
    end else if (hb_valid) begin
      rf_we_d      = 1'b1;
      rf_wr_d.addr = hb_addr;
      rf_wr_d.data = hb_data;
      hb_clear     = 1'b1;
      mdu_wr       = 1'b1;
      mdu_wr_reg   = hb_addr;
    end else if (accept) begin
      rf_we_d      = 1'b1;
      rf_wr_d.addr = mdu_reg;
      rf_wr_d.data = mdu_data;
      mdu_wr       = 1'b1;
      mdu_wr_reg   = mdu_reg;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && pipe_we) begin
          hb_load = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (hb_clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (pipe_we) begin
          cnt_d = (cnt_q >= LIMIT) ? LIMIT : CNT_W'(cnt_q + 1'b1);
          if (cnt_d == LIMIT) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (hb_clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new issue to the same register outranks the clear from its older result.
    if (mdu_wr)    busy_d[mdu_wr_reg]    = 1'b0;
    if (mdu_issue) busy_d[mdu_issue_reg] = 1'b1;

    stall_d = (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rf_we_q <= 1'b0;
      rf_wr_q <= '0;
      busy_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_we_q <= rf_we_d;
      rf_wr_q <= rf_wr_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_wr_q.addr;
  assign rf_wdata  = rf_wr_q.data;
  assign busy_mask = busy_q;
  assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus starvation and reset-in-drain sequences.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [2:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [2:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        mdu_issue;
  logic [2:0]  mdu_issue_reg;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  busy_mask;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        pwe;
    logic [2:0]  preg;
    logic [31:0] pdat;
    logic        mv;
    logic [2:0]  mreg;
    logic [31:0] mdat;
    logic        iss;
    logic [2:0]  ireg;
    logic        e_rdy;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [31:0] e_wd;
    logic [7:0]  e_busy;
    logic        e_stall;
  } vec_t;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [7:0]  busy;
    logic        stall;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[12];

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_we       (pipe_we),
    .pipe_reg      (pipe_reg),
    .pipe_data     (pipe_data),
    .mdu_valid     (mdu_valid),
    .mdu_reg       (mdu_reg),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .mdu_issue     (mdu_issue),
    .mdu_issue_reg (mdu_issue_reg),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy_mask     (busy_mask),
    .stall_req     (stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input logic pwe, input logic [2:0] preg, input logic [31:0] pdat,
    input logic mv, input logic [2:0] mreg, input logic [31:0] mdat,
    input logic iss, input logic [2:0] ireg,
    input logic e_rdy, input logic e_we, input logic [2:0] e_wa, input logic [31:0] e_wd,
    input logic [7:0] e_busy, input logic e_stall);
    vec_t v;
    v.pwe = pwe;  v.preg = preg; v.pdat = pdat;
    v.mv = mv;    v.mreg = mreg; v.mdat = mdat;
    v.iss = iss;  v.ireg = ireg;
    v.e_rdy = e_rdy; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_busy = e_busy; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
    mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0;
    mdu_issue = 1'b0; mdu_issue_reg = '0;
  endtask

  // Drive one cycle of stimulus, push the registered result expected after the edge, then compare.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    @(negedge clk);
    pipe_we = v.pwe; pipe_reg = v.preg; pipe_data = v.pdat;
    mdu_valid = v.mv; mdu_reg = v.mreg; mdu_data = v.mdat;
    mdu_issue = v.iss; mdu_issue_reg = v.ireg;
    #1;
    chk({nm, " mdu_ready"}, 32'(mdu_ready), 32'(v.e_rdy));
    e.name = nm; e.we = v.e_we; e.wa = v.e_wa; e.wd = v.e_wd;
    e.busy = v.e_busy; e.stall = v.e_stall;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sbq.pop_front();
      chk({e.name, " rf_we"}, 32'(rf_we), 32'(e.we));
      chk({e.name, " rf_waddr"}, 32'(rf_waddr), 32'(e.wa));
      chk({e.name, " rf_wdata"}, rf_wdata, e.wd);
      chk({e.name, " busy_mask"}, 32'(busy_mask), 32'(e.busy));
      chk({e.name, " stall_req"}, 32'(stall_req), 32'(e.stall));
    end
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " rf_we"}, 32'(rf_we), 32'd0);
    chk({nm, " rf_waddr"}, 32'(rf_waddr), 32'd0);
    chk({nm, " rf_wdata"}, rf_wdata, 32'd0);
    chk({nm, " busy_mask"}, 32'(busy_mask), 32'd0);
    chk({nm, " stall_req"}, 32'(stall_req), 32'd0);
    chk({nm, " mdu_ready"}, 32'(mdu_ready), 32'd1);
  endtask

  initial begin
    //               pwe preg pdat          mv mreg mdat          iss ireg rdy we wa wd            busy   stall
    tbl[0]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         8'h00, 0);
    tbl[1]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 5, 1, 0, 0, 32'h0,         8'h20, 0);
    tbl[2]  = mk(0, 0, 32'h0,         1, 5, 32'hDEADBEEF,  0, 0, 1, 1, 5, 32'hDEADBEEF,  8'h00, 0);
    tbl[3]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 1, 0, 0, 32'h0,         8'h08, 0);
    tbl[4]  = mk(1, 2, 32'h11,        1, 3, 32'h22,        0, 0, 1, 1, 2, 32'h11,        8'h08, 0);
    tbl[5]  = mk(0, 0, 32'h0,         1, 6, 32'h66,        0, 0, 0, 1, 3, 32'h22,        8'h00, 0);
    tbl[6]  = mk(0, 0, 32'h0,         1, 6, 32'h66,        0, 0, 1, 1, 6, 32'h66,        8'h00, 0);
    tbl[7]  = mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 4, 1, 0, 0, 32'h0,         8'h10, 0);
    tbl[8]  = mk(0, 0, 32'h0,         1, 4, 32'h44,        1, 4, 1, 1, 4, 32'h44,        8'h10, 0);
    tbl[9]  = mk(1, 4, 32'hAAAA0000,  0, 0, 32'h0,         0, 0, 1, 1, 4, 32'hAAAA0000,  8'h10, 0);
    tbl[10] = mk(0, 0, 32'h0,         1, 4, 32'h4444,      0, 0, 1, 1, 4, 32'h4444,      8'h00, 0);
    tbl[11] = mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         8'h00, 0);

    rst_n = 1'b0;
    drive_idle();
    #12;
    chk_zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Starvation: held entry waits through four pipeline writes, then forces a stall.
    step(mk(1, 0, 32'h100, 1, 1, 32'hB1, 0, 0, 1, 1, 0, 32'h100, 8'h00, 0), "starve_collide");
    for (int i = 1; i <= 4; i++)
      step(mk(1, 7, 32'(i), 0, 0, 32'h0, 0, 0, 0, 1, 7, 32'(i), 8'h00, logic'(i == 4)),
           $sformatf("starve_wait%0d", i));
    step(mk(1, 7, 32'h5, 0, 0, 32'h0, 0, 0, 0, 1, 7, 32'h5, 8'h00, 1), "drain_pipe_wins");
    step(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 32'hB1, 8'h00, 0), "drain_write");
    step(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 8'h00, 0), "drain_after");

    // Reset while draining: held 0x55 must be dropped and the scoreboard cleared.
    step(mk(1, 0, 32'h1, 1, 2, 32'h55, 1, 2, 1, 1, 0, 32'h1, 8'h04, 0), "rst_collide");
    for (int i = 1; i <= 4; i++)
      step(mk(1, 7, 32'h2, 0, 0, 32'h0, 0, 0, 0, 1, 7, 32'h2, 8'h04, logic'(i == 4)),
           $sformatf("rst_wait%0d", i));
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("rst_drain_async");
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 8'h00, 0), "post_rst0");
    step(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 8'h00, 0), "post_rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
